// File: rtl/ocin_input_conditioner.sv
// ocin_input_conditioner: per-line synchroniser, debouncer and edge detector
// for the 30 raw OCIN inputs. Masked rise/fall events are latched into a
// write-1-to-clear register, and any set bit drives a level interrupt.
// Optional snapshot capture of the debounced levels: OCIN_COND_SNAPSHOT_EN.
module ocin_input_conditioner #(
    parameter int WIDTH     = 30,
    parameter int PRESCALE  = 125,
    parameter int DEB_TICKS = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] in_raw_i,
    input  logic [WIDTH-1:0] in_enable_i,
    input  logic [WIDTH-1:0] rise_mask_i,
    input  logic [WIDTH-1:0] fall_mask_i,
    input  logic [WIDTH-1:0] evt_clr_i,
    input  logic             evt_clr_stb_i,
`ifdef OCIN_COND_SNAPSHOT_EN
    input  logic             snap_stb_i,
    output logic [WIDTH-1:0] snap_o,
    output logic             snap_valid_o,
`endif
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] evt_o,
    output logic             irq_o
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  DEB_LAST      = 8'(DEB_TICKS - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [15:0]      presc_r;
    logic             tick_s;
    logic [7:0]       cnt_r     [WIDTH];
    logic [7:0]       cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] stable_nxt_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] evt_r;
    logic [WIDTH-1:0] evt_clr_s;
    logic             irq_r;

    assign tick_s    = (presc_r == PRESCALE_LAST);
    assign evt_clr_s = evt_clr_i & {WIDTH{evt_clr_stb_i}};

    // Two-stage synchroniser for the asynchronous raw lines.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= in_raw_i;
            sync2_r <= sync1_r;
        end
    end

    // Debounce tick prescaler, shared by all lines.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_r <= 16'd0;
        end else if (tick_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // Per-line acceptance decision: a changed level must survive DEB_TICKS ticks.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i]    = cnt_r[i];
            stable_nxt_s[i] = stable_r[i];
            if (!in_enable_i[i]) begin
                cnt_nxt_s[i]    = 8'd0;
                stable_nxt_s[i] = 1'b0;
            end else if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = 8'd0;
            end else if (tick_s) begin
                if (cnt_r[i] == DEB_LAST) begin
                    cnt_nxt_s[i]    = 8'd0;
                    stable_nxt_s[i] = sync2_r[i];
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + 8'd1;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Debounce counters and accepted levels.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= 8'd0;
            end
            stable_r <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            stable_r <= stable_nxt_s;
        end
    end

    // Edge pulses one cycle after the accepted level changes; a disabled
    // line never pulses, so forcing its level low is not reported as a fall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_r <= '0;
            rise_r <= '0;
            fall_r <= '0;
        end else begin
            prev_r <= stable_r;
            rise_r <= in_enable_i & stable_r & ~prev_r;
            fall_r <= in_enable_i & ~stable_r & prev_r;
        end
    end

    // Event latch: masked edges set, strobed write-1 clears, set wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            evt_r <= '0;
        end else begin
            evt_r <= (evt_r & ~evt_clr_s) | (rise_r & rise_mask_i) | (fall_r & fall_mask_i);
        end
    end

    // Level interrupt, registered from the latched events.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |evt_r;
        end
    end

`ifdef OCIN_COND_SNAPSHOT_EN
    logic [WIDTH-1:0] snap_r;
    logic             snap_valid_r;

    // Snapshot of debounced levels; a new capture takes priority over the clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            snap_r       <= '0;
            snap_valid_r <= 1'b0;
        end else if (snap_stb_i) begin
            snap_r       <= stable_r;
            snap_valid_r <= 1'b1;
        end else if (evt_clr_stb_i) begin
            snap_valid_r <= 1'b0;
        end else begin
            snap_valid_r <= snap_valid_r;
        end
    end

    assign snap_o       = snap_r;
    assign snap_valid_o = snap_valid_r;
`endif

    assign stable_o = stable_r;
    assign rise_o   = rise_r;
    assign fall_o   = fall_r;
    assign evt_o    = evt_r;
    assign irq_o    = irq_r;

endmodule

// File: tb/tb_ocin_input_conditioner.sv
// Self-checking bench for ocin_input_conditioner (PRESCALE=4, DEB_TICKS=3).
// The reference model decides acceptance by counting debounce ticks that fall
// inside the interval a line has differed from its accepted level.
module tb_ocin_input_conditioner;

    localparam int W   = 30;
    localparam int P   = 4;
    localparam int DEB = 3;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_raw;
    logic [W-1:0]  in_enable;
    logic [W-1:0]  rise_mask;
    logic [W-1:0]  fall_mask;
    logic [W-1:0]  evt_clr;
    logic          evt_clr_stb;
    logic [W-1:0]  stable_o;
    logic [W-1:0]  rise_o;
    logic [W-1:0]  fall_o;
    logic [W-1:0]  evt_o;
    logic          irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int            c;              // clock edges since reset release
    int            run_start [W];  // edge where current divergence began, -1 if none
    logic [W-1:0]  m_s1, m_s2, m_stable, m_prev, m_rise, m_fall, m_evt;
    logic          m_irq;

    ocin_input_conditioner #(.WIDTH(W), .PRESCALE(P), .DEB_TICKS(DEB)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .in_raw_i      (in_raw),
        .in_enable_i   (in_enable),
        .rise_mask_i   (rise_mask),
        .fall_mask_i   (fall_mask),
        .evt_clr_i     (evt_clr),
        .evt_clr_stb_i (evt_clr_stb),
        .stable_o      (stable_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .evt_o         (evt_o),
        .irq_o         (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // number of tick edges (edge index mod P == P-1) in the edge range [a, b]
    function automatic int ticks_between(input int a, input int b);
        return (b + 1) / P - a / P;
    endfunction

    task automatic model_reset();
        c = 0;
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
        m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
        for (int i = 0; i < W; i++) run_start[i] = -1;
    endtask

    task automatic model_step();
        logic [W-1:0] n_stable;
        logic [W-1:0] clr;
        n_stable = m_stable;
        for (int i = 0; i < W; i++) begin
            if (!in_enable[i]) begin
                n_stable[i] = 1'b0;
                run_start[i] = -1;
            end else if (m_s2[i] == m_stable[i]) begin
                run_start[i] = -1;
            end else begin
                if (run_start[i] < 0) run_start[i] = c;
                if ((c % P) == P - 1 && ticks_between(run_start[i], c) == DEB) begin
                    n_stable[i] = m_s2[i];
                    run_start[i] = -1;
                end
            end
        end
        clr    = evt_clr_stb ? evt_clr : '0;
        m_irq  = |m_evt;
        m_evt  = (m_evt & ~clr) | (m_rise & rise_mask) | (m_fall & fall_mask);
        m_rise = in_enable & m_stable & ~m_prev;
        m_fall = in_enable & ~m_stable & m_prev;
        m_prev = m_stable;
        m_stable = n_stable;
        m_s2 = m_s1;
        m_s1 = in_raw;
        c++;
    endtask

    // advance one clock edge, update the model, and leave time for outputs to settle
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_raw = '0; in_enable = '1; rise_mask = '0; fall_mask = '0;
        evt_clr = '0; evt_clr_stb = 1'b0;
        model_reset();
        #22;
        n_checks++;
        if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stable=%h rise=%h fall=%h evt=%h irq=%b, want all 0", stable_o, rise_o, fall_o, evt_o, irq_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            n_checks++;
            if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: got stable=%h evt=%h irq=%b, want 0", stable_o, evt_o, irq_o);
            end
        end
    endtask

    task automatic test_rise_latency();
        int lat = 0;
        int rise_cnt = 0;
        int rise_at = 0;
        in_raw[0] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            if (stable_o[0] && lat == 0) lat = k;
            if (rise_o[0]) begin rise_cnt++; rise_at = k; end
            n_checks++;
            if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== {m_stable, m_rise, m_fall, m_evt, m_irq}) begin
                n_fail++;
                $display("FAIL rise_model k=%0d: got stable=%h rise=%h fall=%h evt=%h irq=%b, want %h %h %h %h %b", k, stable_o, rise_o, fall_o, evt_o, irq_o, m_stable, m_rise, m_fall, m_evt, m_irq);
            end
        end
        n_checks++;
        if (lat < 2 + 9 || lat > 2 + 12) begin
            n_fail++;
            $display("FAIL rise_latency: got %0d cycles, want 11..14", lat);
        end
        n_checks++;
        if (rise_cnt != 1 || rise_at != lat + 1) begin
            n_fail++;
            $display("FAIL rise_pulse: got %0d pulses at cycle %0d, want 1 at %0d", rise_cnt, rise_at, lat + 1);
        end
    endtask

    task automatic test_glitch();
        int idle;
        rise_mask = '1; fall_mask = '1;
        idle = $urandom_range(0, 3);
        for (int k = 0; k < idle; k++) cyc();
        in_raw[5] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 6) in_raw[5] = 1'b0;
            cyc();
            n_checks++;
            if (stable_o[5] !== 1'b0 || rise_o[5] !== 1'b0 || evt_o[5] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_bit5 k=%0d: got stable=%b rise=%b evt=%b, want 0 0 0", k, stable_o[5], rise_o[5], evt_o[5]);
            end
            n_checks++;
            if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== {m_stable, m_rise, m_fall, m_evt, m_irq}) begin
                n_fail++;
                $display("FAIL glitch_model k=%0d: got stable=%h evt=%h, want %h %h", k, stable_o, evt_o, m_stable, m_evt);
            end
        end
    endtask

    task automatic test_event_mask();
        int t_evt = 0;
        int t_irq = 0;
        rise_mask = 30'h1; fall_mask = 30'h0;
        in_raw[0] = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        evt_clr = '1; evt_clr_stb = 1'b1;
        cyc();
        evt_clr = '0; evt_clr_stb = 1'b0;
        cyc(); cyc();
        n_checks++;
        if (evt_o !== 30'h0 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL evt_clear_all: got evt=%h irq=%b, want 0 0", evt_o, irq_o);
        end
        in_raw[0] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (evt_o[0] && t_evt == 0) t_evt = k;
            if (irq_o && t_irq == 0) t_irq = k;
            n_checks++;
            if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== {m_stable, m_rise, m_fall, m_evt, m_irq}) begin
                n_fail++;
                $display("FAIL mask_model k=%0d: got evt=%h irq=%b, want %h %b", k, evt_o, irq_o, m_evt, m_irq);
            end
        end
        n_checks++;
        if (evt_o !== 30'h1) begin
            n_fail++;
            $display("FAIL evt_after_rise: got %h, want 00000001", evt_o);
        end
        n_checks++;
        if (t_evt == 0 || t_irq != t_evt + 1) begin
            n_fail++;
            $display("FAIL irq_delay: evt at %0d irq at %0d, want irq one cycle after evt", t_evt, t_irq);
        end
        in_raw[0] = 1'b0;
        for (int k = 0; k < 25; k++) cyc();
        n_checks++;
        if (evt_o !== 30'h1 || stable_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL evt_after_fall: got evt=%h stable0=%b, want 00000001 0", evt_o, stable_o[0]);
        end
    endtask

    task automatic test_set_clear_collision();
        bit seen = 0;
        int guard = 0;
        in_raw[0] = 1'b1;
        while (!seen && guard < 40) begin
            cyc();
            guard++;
            if (m_rise[0]) begin
                seen = 1;
                evt_clr = 30'h1; evt_clr_stb = 1'b1;
                cyc();
                evt_clr = '0; evt_clr_stb = 1'b0;
                n_checks++;
                if (evt_o[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL collision_set_wins: got evt0=%b, want 1", evt_o[0]);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL collision_timeout: no rise within 40 cycles");
        end
        cyc(); cyc();
        evt_clr = 30'h1; evt_clr_stb = 1'b1;
        cyc();
        evt_clr = '0; evt_clr_stb = 1'b0;
        n_checks++;
        if (evt_o !== 30'h0 || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_alone: got evt=%h irq=%b, want 0 1", evt_o, irq_o);
        end
        cyc();
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_drop: got %b, want 0", irq_o);
        end
    endtask

    task automatic test_disable();
        int lat = 0;
        int rise_at = 0;
        in_enable[3] = 1'b0;
        in_raw[3] = 1'b1;
        rise_mask = '1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            n_checks++;
            if (stable_o[3] !== 1'b0 || rise_o[3] !== 1'b0 || fall_o[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled_bit3 k=%0d: got stable=%b rise=%b fall=%b, want 0 0 0", k, stable_o[3], rise_o[3], fall_o[3]);
            end
        end
        in_enable[3] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (stable_o[3] && lat == 0) lat = k;
            if (rise_o[3] && rise_at == 0) rise_at = k;
            n_checks++;
            if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== {m_stable, m_rise, m_fall, m_evt, m_irq}) begin
                n_fail++;
                $display("FAIL enable_model k=%0d: got stable=%h rise=%h evt=%h, want %h %h %h", k, stable_o, rise_o, evt_o, m_stable, m_rise, m_evt);
            end
        end
        n_checks++;
        if (lat < 9 || lat > 12 || rise_at != lat + 1) begin
            n_fail++;
            $display("FAIL enable_latency: stable at %0d rise at %0d, want 9..12 and rise one later", lat, rise_at);
        end
    endtask

    task automatic test_reset_mid_count();
        bit hit = 0;
        int lat = 0;
        in_raw[7] = 1'b1;
        for (int k = 0; k < 20 && !hit; k++) begin
            cyc();
            if (run_start[7] >= 0 && ticks_between(run_start[7], c - 1) == 2) hit = 1;
        end
        n_checks++;
        if (!hit || stable_o[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL midcount_reach: hit=%0d stable7=%b, want 1 0", hit, stable_o[7]);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== '0) begin
            n_fail++;
            $display("FAIL midcount_reset: got stable=%h evt=%h irq=%b, want 0", stable_o, evt_o, irq_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (stable_o[7] && lat == 0) lat = k;
            n_checks++;
            if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== {m_stable, m_rise, m_fall, m_evt, m_irq}) begin
                n_fail++;
                $display("FAIL post_reset_model k=%0d: got stable=%h evt=%h, want %h %h", k, stable_o, evt_o, m_stable, m_evt);
            end
        end
        // prescaler restarts at 0: sync takes edges 1-2, ticks on edges 4, 8, 12
        n_checks++;
        if (lat != 12) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d, want 12", lat);
        end
    endtask

    task automatic test_random();
        rise_mask = W'($urandom());
        fall_mask = W'($urandom());
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 11) == 0) in_raw[$urandom_range(10, 13)] ^= 1'b1;
            if ($urandom_range(0, 79) == 0) in_enable[$urandom_range(10, 13)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                rise_mask = W'($urandom());
                fall_mask = W'($urandom());
            end
            evt_clr = W'($urandom());
            evt_clr_stb = ($urandom_range(0, 9) == 0);
            cyc();
            n_checks++;
            if ({stable_o, rise_o, fall_o, evt_o, irq_o} !== {m_stable, m_rise, m_fall, m_evt, m_irq}) begin
                n_fail++;
                $display("FAIL random_model k=%0d: got stable=%h rise=%h fall=%h evt=%h irq=%b, want %h %h %h %h %b", k, stable_o, rise_o, fall_o, evt_o, irq_o, m_stable, m_rise, m_fall, m_evt, m_irq);
            end
        end
        evt_clr_stb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_event_mask();
        test_set_clear_collision();
        test_disable();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
